// File: rtl/ysyx_22041752_ex_ctrl.sv
// Execute-stage holding register and stall controller between ID, the ALU and MEM.
// Define YSYX_22041752_EX_PERF_CNT_EN to add saturating stall counters.
module ysyx_22041752_ex_ctrl #(
  parameter int BUS_W = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_bus,
  input  logic             in_mc,
  input  logic             in_is_div,
  output logic [BUS_W-1:0] ex_bus,
  output logic             mc_go,
  input  logic [63:0]      alu_result,
  input  logic             mul_out_valid,
  input  logic             div_out_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_bus,
`ifdef YSYX_22041752_EX_PERF_CNT_EN
  output logic [31:0]      stall_mc_cnt,
  output logic [31:0]      stall_out_cnt,
`endif
  output logic [63:0]      out_result
);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] SINGLE  = 2'd1;
  localparam logic [1:0] WAIT_MC = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             kind_div;
  logic [BUS_W-1:0] bus_q;
  logic [63:0]      result_q;
  logic             accept;
  logic             mc_done;

  assign out_valid  = (state == SINGLE) || (state == DONE);
  assign mc_go      = (state == WAIT_MC);
  assign in_ready   = (state == EMPTY) || (out_valid && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  // Only the completion pulse of the unit actually running the held op counts.
  assign mc_done    = (state == WAIT_MC) && (kind_div ? div_out_valid : mul_out_valid);
  assign ex_bus     = bus_q;
  assign out_bus    = bus_q;
  assign out_result = (state == SINGLE) ? alu_result : result_q;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = in_mc ? WAIT_MC : SINGLE;
    end else begin
      case (state)
        SINGLE, DONE: if (out_ready) state_nxt = EMPTY;
        WAIT_MC:      if (mc_done) state_nxt = DONE;
        default:      state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      kind_div <= 1'b0;
      bus_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        kind_div <= in_is_div;
        bus_q    <= in_bus;
      end
      // A flush in the completion cycle discards the result entirely.
      if (mc_done && !flush) result_q <= alu_result;
    end
  end

`ifdef YSYX_22041752_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_mc_cnt  <= '0;
      stall_out_cnt <= '0;
    end else begin
      if (mc_go && (stall_mc_cnt != 32'hFFFF_FFFF)) stall_mc_cnt <= stall_mc_cnt + 32'd1;
      if (out_valid && !out_ready && (stall_out_cnt != 32'hFFFF_FFFF))
        stall_out_cnt <= stall_out_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041752_ex_ctrl.sv
// Bench for ysyx_22041752_ex_ctrl: directed scenarios then random traffic against
// an instruction-level model (held bundle, multi-cycle done flag, captured result).
module tb_ysyx_22041752_ex_ctrl;
  localparam int BUS_W = 192;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_bus;
  logic             in_mc;
  logic             in_is_div;
  logic [BUS_W-1:0] ex_bus;
  logic             mc_go;
  logic [63:0]      alu_result;
  logic             mul_out_valid;
  logic             div_out_valid;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_bus;
  logic [63:0]      out_result;
`ifdef YSYX_22041752_EX_PERF_CNT_EN
  logic [31:0]      stall_mc_cnt;
  logic [31:0]      stall_out_cnt;
  logic [31:0]      m_stall_mc;
  logic [31:0]      m_stall_out;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int go_cnt;

  // Model of the instruction currently held in EX, not of any state encoding
  logic             m_have;
  logic             m_mc;
  logic             m_kind_div;
  logic             m_done;
  logic [BUS_W-1:0] m_bus;
  logic [63:0]      m_res;

  always #5 clk = ~clk;

  ysyx_22041752_ex_ctrl #(.BUS_W(BUS_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_bus        (in_bus),
    .in_mc         (in_mc),
    .in_is_div     (in_is_div),
    .ex_bus        (ex_bus),
    .mc_go         (mc_go),
    .alu_result    (alu_result),
    .mul_out_valid (mul_out_valid),
    .div_out_valid (div_out_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bus       (out_bus),
`ifdef YSYX_22041752_EX_PERF_CNT_EN
    .stall_mc_cnt  (stall_mc_cnt),
    .stall_out_cnt (stall_out_cnt),
`endif
    .out_result    (out_result)
  );

  function automatic logic f_out_valid();
    return m_have && (!m_mc || m_done);
  endfunction

  function automatic logic f_mc_go();
    return m_have && m_mc && !m_done;
  endfunction

  function automatic logic f_in_ready();
    return !m_have || (f_out_valid() && out_ready);
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [BUS_W-1:0] obs,
                            input logic [BUS_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have     = 1'b0;
    m_mc       = 1'b0;
    m_kind_div = 1'b0;
    m_done     = 1'b0;
    m_bus      = '0;
    m_res      = '0;
`ifdef YSYX_22041752_EX_PERF_CNT_EN
    m_stall_mc  = '0;
    m_stall_out = '0;
`endif
  endtask

  task automatic apply_stimulus(input logic v, input logic [BUS_W-1:0] b, input logic mc,
                                input logic is_div, input logic [63:0] alu, input logic mv,
                                input logic dv, input logic ordy, input logic fl);
    in_valid      = v;
    in_bus        = b;
    in_mc         = mc;
    in_is_div     = is_div;
    alu_result    = alu;
    mul_out_valid = mv;
    div_out_valid = dv;
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic check_output();
    check_bit("out_valid", out_valid, f_out_valid());
    check_bit("mc_go", mc_go, f_mc_go());
    check_bit("in_ready", in_ready, f_in_ready());
    check_wide("ex_bus", ex_bus, m_bus);
    check_wide("out_bus", out_bus, m_bus);
    if (f_out_valid())
      check_wide("out_result", BUS_W'(out_result), BUS_W'(m_mc ? m_res : alu_result));
`ifdef YSYX_22041752_EX_PERF_CNT_EN
    check_wide("stall_mc_cnt", BUS_W'(stall_mc_cnt), BUS_W'(m_stall_mc));
    check_wide("stall_out_cnt", BUS_W'(stall_out_cnt), BUS_W'(m_stall_out));
`endif
  endtask

  task automatic model_update();
    logic ov;
    logic ir;
    logic go;
    logic acc;
    ov  = f_out_valid();
    ir  = f_in_ready();
    go  = f_mc_go();
    acc = in_valid && ir && !flush;
`ifdef YSYX_22041752_EX_PERF_CNT_EN
    if (go && m_stall_mc != 32'hFFFF_FFFF) m_stall_mc = m_stall_mc + 32'd1;
    if (ov && !out_ready && m_stall_out != 32'hFFFF_FFFF) m_stall_out = m_stall_out + 32'd1;
`endif
    if (flush) begin
      m_have = 1'b0;
    end else if (acc) begin
      m_have     = 1'b1;
      m_mc       = in_mc;
      m_kind_div = in_is_div;
      m_done     = 1'b0;
      m_bus      = in_bus;
    end else if (ov && out_ready) begin
      m_have = 1'b0;
    end else if (go && (m_kind_div ? div_out_valid : mul_out_valid)) begin
      m_done = 1'b1;
      m_res  = alu_result;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_output();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [BUS_W-1:0] bus_a;
    logic [BUS_W-1:0] bus_b;
    logic [63:0]      held;

    reset = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_output();
    check_bit("reset_out_valid", out_valid, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    $display("[TB] single-cycle stream");
    for (int k = 0; k <= 3; k++) begin
      apply_stimulus(k < 3, BUS_W'(64'hA0 + k), 1'b0, 1'b0, 64'(k), 1'b0, 1'b0, 1'b1, 1'b0);
      sample();
      check_bit("stream_in_ready", in_ready, 1'b1);
      if (k > 0) check_wide("stream_result", BUS_W'(out_result), BUS_W'(k));
      tick();
    end

    $display("[TB] multiply");
    bus_a = rand_bus();
    apply_stimulus(1'b1, bus_a, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();
    go_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, (k == 5) ? 64'hDEAD_BEEF_0000_0001 : 64'(k),
                     k == 5, 1'b0, 1'b0, 1'b0);
      sample();
      go_cnt += int'(mc_go);
      tick();
    end
    check_wide("mul_go_cycles", BUS_W'(go_cnt), BUS_W'(5));
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check_wide("mul_result_held", BUS_W'(out_result), BUS_W'(64'hDEAD_BEEF_0000_0001));
      check_wide("mul_bus_held", out_bus, bus_a);
      tick();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();

    $display("[TB] divide with stray multiply pulse");
    apply_stimulus(1'b1, rand_bus(), 1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();
    for (int k = 1; k <= 35; k++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b0,
                     (k == 34) ? 64'h0000_1234_5678_9ABC : {$urandom(), $urandom()},
                     k == 2, k == 34, 1'b0, 1'b0);
      sample();
      if (k == 33) check_bit("div_still_waiting", mc_go, 1'b1);
      if (k == 35) check_wide("div_result", BUS_W'(out_result), BUS_W'(64'h0000_1234_5678_9ABC));
      tick();
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();

    $display("[TB] backpressure");
    bus_a = rand_bus();
    bus_b = rand_bus();
    held  = {$urandom(), $urandom()};
    apply_stimulus(1'b1, bus_a, 1'b0, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    tick();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, bus_b, 1'b0, 1'b0, held, 1'b0, 1'b0, 1'b0, 1'b0);
      sample();
      check_bit("bp_in_ready", in_ready, 1'b0);
      check_wide("bp_out_bus", out_bus, bus_a);
      tick();
    end
    apply_stimulus(1'b1, bus_b, 1'b0, 1'b0, held, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    check_bit("bp_release_ready", in_ready, 1'b1);
    tick();
    check_wide("bp_next_bus", out_bus, bus_b);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();

    $display("[TB] flush on divide completion");
    apply_stimulus(1'b1, rand_bus(), 1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 64'hBAD, 1'b0, k == 4, 1'b1, k == 4);
      sample();
      if (k > 4) check_bit("flush_out_valid", out_valid, 1'b0);
      tick();
    end

    $display("[TB] async reset while waiting on multiply");
    apply_stimulus(1'b1, rand_bus(), 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    sample();
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_mc_go", mc_go, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_output();
    #2;
    reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    $display("[TB] random traffic");
    for (int k = 0; k < 3000; k++) begin
      apply_stimulus(($urandom() % 4) != 0, rand_bus(), ($urandom() % 3) == 0, $urandom() % 2 == 1,
                     {$urandom(), $urandom()}, ($urandom() % 5) == 0, ($urandom() % 7) == 0,
                     ($urandom() % 4) != 0, ($urandom() % 23) == 0);
      sample();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_ex_ctrl.md
Name: ysyx_22041752_ex_ctrl

Overview:
Execute-stage pipeline register and stall controller that sits directly upstream of the ALU. It accepts one decoded instruction bundle from ID, holds the operands and op decode steady while the ALU works, and waits for multi-cycle mul/div/rem completion. It then presents the result to MEM with a valid/ready handshake, and handles flush.

Parameters:
BUS_W, 192, width of the opaque decoded payload (operands, op one-hots, pc, rd) carried ID→EX→MEM.

Ports:
clk            in   1      clock, all state on rising edge
reset          in   1      asynchronous, active-low reset
flush          in   1      synchronous kill of the held instruction (redirect/exception)
in_valid       in   1      ID has a bundle
in_ready       out  1      EX can accept this cycle
in_bus         in   BUS_W  decoded bundle from ID
in_mc          in   1      bundle is mul/div/rem (multi-cycle)
in_is_div      in   1      multi-cycle op is div/rem (else mul); valid with in_mc
ex_bus         out  BUS_W  held bundle driven to ALU decode/operands
mc_go          out  1      qualifies op_mul/op_div/op_rem into the ALU; high only in WAIT_MC
alu_result     in   64     ALU combinational result
mul_out_valid  in   1      multiplier done pulse
div_out_valid  in   1      divider done pulse
out_valid      out  1      result available to MEM
out_ready      in   1      MEM accepts
out_bus        out  BUS_W  held bundle to MEM
out_result     out  64     result to MEM

Behaviour:
- States: EMPTY, SINGLE, WAIT_MC, DONE (2-bit). Reset → EMPTY, ex_bus/out_bus=0, result register=0, out_valid=0, mc_go=0.
- in_ready = (state==EMPTY) | (out_valid & out_ready). Accept means in_valid & in_ready & !flush.
- Accept while in_mc=0 → SINGLE. Accept while in_mc=1 → WAIT_MC, and latch in_is_div into kind_div.
- SINGLE: out_valid=1, out_result=alu_result (combinational pass-through). Latency is 1 cycle from accept.
- WAIT_MC: mc_go=1, out_valid=0. Done = kind_div ? div_out_valid : mul_out_valid. Done in any cycle → capture alu_result into result register, go to DONE. The pulse of the wrong kind is ignored.
- DONE: out_valid=1, out_result=result register, mc_go=0.
- SINGLE/DONE with out_ready=1: on the same cycle, accept a new bundle if one is offered (back-to-back, no bubble). Otherwise go to EMPTY.
- SINGLE/DONE with out_ready=0: hold state. ex_bus, out_bus and out_result stay stable.
- ex_bus and out_bus are the same held register, loaded only on accept.
- flush has priority over everything: next state EMPTY, out_valid=0 next cycle, done pulses in the same cycle are discarded, and no accept occurs that cycle. The bundle register is not cleared.
- A done pulse arriving while in EMPTY/SINGLE/DONE is ignored.
- Asynchronous reset mid-WAIT_MC → EMPTY immediately. The ALU's multi-cycle units are reset separately.
- Minimum multi-cycle latency: done in the cycle after accept gives out_valid 2 cycles after accept.

Optional Feature:
Macro YSYX_22041752_EX_PERF_CNT_EN.
- Defined: adds outputs stall_mc_cnt[31:0] and stall_out_cnt[31:0].
  - stall_mc_cnt increments each cycle in WAIT_MC.
  - stall_out_cnt increments each cycle with out_valid & !out_ready.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are unaffected by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset low mid-WAIT_MC → out_valid=0, mc_go=0, in_ready=1 the same cycle. After release, EMPTY.
- Single-cycle stream: in_valid=1 every cycle with bundles A,B,C, in_mc=0, out_ready=1, alu_result=0x1,0x2,0x3 → out_valid continuous from cycle 1, out_result sequence 0x1,0x2,0x3, in_ready never drops.
- Mul: in_mc=1, in_is_div=0, mul_out_valid pulsed 5 cycles after accept with alu_result=0xDEAD_BEEF_0000_0001 → mc_go high for 5 cycles. Then out_valid=1, out_result=0xDEADBEEF00000001, held while alu_result changes.
- Div with a stray mul_out_valid pulse at cycle 2 and div_out_valid at cycle 34 → state stays WAIT_MC until cycle 34. Result captured only then.
- Backpressure: out_ready=0 for 3 cycles in SINGLE → in_ready=0, out_bus/out_result stable. Raise out_ready with in_valid=1 → new bundle accepted that cycle.
- flush in the same cycle as div_out_valid → EMPTY, out_valid stays 0, result register unchanged. With PERF_CNT_EN, stall_mc_cnt holds its count.
